// File: rtl/cacheline_burst_adapter_if.sv
// Bus bundle between the eviction write buffer (line side) and physical
// memory (beat side) for the cache-line burst adapter.
interface cacheline_burst_adapter_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
);
    // line side
    logic [ADDR_WIDTH-1:0]  address_i;
    logic                   read_i;
    logic                   write_i;
    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic                   resp_o;
    // memory beat side
    logic [ADDR_WIDTH-1:0]  address_o;
    logic                   read_o;
    logic                   write_o;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [BURST_WIDTH-1:0] burst_i;
    logic                   resp_i;

    // the adapter itself
    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    // the environment around the adapter (requester plus memory)
    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Cache-line to memory-burst adapter: one full line is moved per request as
// BEATS consecutive beats, slice 0 first, with a single-cycle done pulse.
module cacheline_burst_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cacheline_burst_adapter_if.slave  bus
);
    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    // One state bit per decoded output so read_o/write_o/resp_o are
    // straight register bits and cannot glitch.
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        READ  = 3'b001,
        WRITE = 3'b010,
        DONE  = 3'b100
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [LINE_WIDTH-1:0]  wr_line;
    logic [LINE_WIDTH-1:0]  rd_line;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  addr_aligned;
    logic                   last_beat;
    logic                   unused_offset;

    assign addr_aligned  = {bus.address_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign last_beat     = bus.resp_i && (cnt == CNT_W'(BEATS - 1));
    assign unused_offset = &{1'b0, bus.address_i[OFF_W-1:0]};

    // State register; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; write has priority over read when both arrive together.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.write_i) begin
                    state_next = WRITE;
                end else if (bus.read_i) begin
                    state_next = READ;
                end
            end
            READ:    if (last_beat) state_next = DONE;
            WRITE:   if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latching, beat counting and read-beat assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            wr_line <= '0;
            rd_line <= '0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.write_i) begin
                        wr_line <= bus.line_i;
                        addr_q  <= addr_aligned;
                    end else if (bus.read_i) begin
                        addr_q  <= addr_aligned;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        rd_line[int'(cnt)*BURST_WIDTH +: BURST_WIDTH] <= bus.burst_i;
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read_o    = state[0];
    assign bus.write_o   = state[1];
    assign bus.resp_o    = state[2];
    assign bus.address_o = addr_q;
    assign bus.line_o    = rd_line;
    // Beat data is only driven while a write burst is active.
    assign bus.burst_o   = state[1] ? wr_line[int'(cnt)*BURST_WIDTH +: BURST_WIDTH]
                                    : '0;
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed bench for cacheline_burst_adapter: reads, writes, stalls,
// request priority, asynchronous abort and spurious memory responses.
module tb_cacheline_burst_adapter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cacheline_burst_adapter_if #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) bus ();

    cacheline_burst_adapter #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read of one line; gap idle cycles precede every beat.
    task automatic run_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [255:0] line, input int gap, input bit hold_done);
        bus.address_i = addr;
        bus.read_i    = 1'b1;
        tick();
        check("rd_start", bus.read_o, 1'b1);
        check("rd_addr", bus.address_o, exp_addr);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                bus.resp_i  = 1'b0;
                bus.burst_i = 64'hBAD0_0000_0000_0000 | 64'(g);
                tick();
                check("rd_stall", {bus.read_o, bus.resp_o, bus.write_o}, 3'b100);
            end
            check("rd_beat", {bus.read_o, bus.resp_o}, 2'b10);
            bus.resp_i  = 1'b1;
            bus.burst_i = line[k*64 +: 64];
            tick();
        end
        bus.resp_i  = hold_done;
        bus.burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        bus.write_i = hold_done;
        bus.line_i  = ~line;
        check("rd_resp", bus.resp_o, 1'b1);
        check("rd_low", bus.read_o, 1'b0);
        check("rd_line", bus.line_o, line);
        bus.read_i = 1'b0;
        tick();
        check("rd_pulse", bus.resp_o, 1'b0);
        check("rd_bubble", {bus.read_o, bus.write_o}, 2'b00);
        check("rd_hold", bus.line_o, line);
        bus.resp_i = 1'b0;
    endtask

    // Full write of one line with the memory accepting a beat every cycle.
    task automatic run_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                             input logic [255:0] line, input bit both,
                             input logic [255:0] keep_line);
        bus.address_i = addr;
        bus.line_i    = line;
        bus.write_i   = 1'b1;
        bus.read_i    = both;
        bus.resp_i    = 1'b1;
        tick();
        bus.line_i = '0;
        for (int k = 0; k < 4; k++) begin
            check("wr_active", {bus.write_o, bus.read_o, bus.resp_o}, 3'b100);
            check("wr_beat", bus.burst_o, line[k*64 +: 64]);
            check("wr_addr", bus.address_o, exp_addr);
            tick();
        end
        bus.resp_i = 1'b0;
        check("wr_resp", bus.resp_o, 1'b1);
        check("wr_low", {bus.write_o, bus.read_o}, 2'b00);
        check("wr_keep", bus.line_o, keep_line);
        bus.write_i = 1'b0;
        bus.read_i  = 1'b0;
        tick();
        check("wr_pulse", bus.resp_o, 1'b0);
    endtask

    localparam logic [255:0] L1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] L2 = {64'h4, 64'h3, 64'h2, 64'h1};
    localparam logic [255:0] L3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    localparam logic [255:0] L4 = {64'h44, 64'h33, 64'h22, 64'h11};
    localparam logic [255:0] L5 = {64'h5D, 64'h5C, 64'h5B, 64'h5A};
    localparam logic [255:0] L6 = {64'h6666_0004, 64'h6666_0003, 64'h6666_0002, 64'h6666_0001};
    localparam logic [255:0] L7 = {64'h7D, 64'h7C, 64'h7B, 64'h7A};

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.line_i    = '0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        tick();
        tick();
        check("rst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
        check("rst_addr", bus.address_o, 32'h0);
        check("rst_line", bus.line_o, 256'h0);
        check("rst_burst", bus.burst_o, 64'h0);
        rst_n = 1'b1;
        tick();

        // basic read with offset bits dropped
        run_read(32'h0000_1234, 32'h0000_1220, L1, 0, 1'b0);
        // basic write, memory always ready
        run_write(32'h0000_8000, 32'h0000_8000, L2, 1'b0, L1);
        // stalled read, one beat every third cycle
        run_read(32'hFFFF_FFFF, 32'hFFFF_FFE0, L3, 2, 1'b0);
        // simultaneous read and write: write wins
        run_write(32'h0000_0040, 32'h0000_0040, L4, 1'b1, L3);

        // reset during a write after two beats
        bus.address_i = 32'h0000_0500;
        bus.line_i    = L7;
        bus.write_i   = 1'b1;
        bus.resp_i    = 1'b1;
        tick();
        tick();
        tick();
        check("ab_beat2", bus.burst_o, 64'h7C);
        rst_n = 1'b0;
        #1;
        check("ab_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
        check("ab_addr", bus.address_o, 32'h0);
        check("ab_burst", bus.burst_o, 64'h0);
        check("ab_line", bus.line_o, 256'h0);
        bus.write_i = 1'b0;
        bus.resp_i  = 1'b0;
        tick();
        check("ab_no_resp", bus.resp_o, 1'b0);
        rst_n = 1'b1;
        tick();
        run_read(32'h0000_001F, 32'h0000_0000, L5, 0, 1'b0);

        // spurious memory responses while idle
        bus.resp_i  = 1'b1;
        bus.burst_i = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
            check("idle_line", bus.line_o, L5);
        end
        bus.resp_i = 1'b0;

        // back-to-back read then write; responses and a write during DONE are ignored
        run_read(32'h0000_0100, 32'h0000_0100, L6, 0, 1'b1);
        run_write(32'h0000_0200, 32'h0000_0200, L2, 1'b0, L6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
